bpu_gshare: RTL and testbench

- Parametrised branch prediction unit for the 5-stage MIPS pipeline. It replaces fixed static guessing with a direct-mapped BTB plus 2-bit saturating counters, in bimodal or gshare mode.
- Lookup is indexed by the F-stage PC. The result is registered into D alignment, where it drives the guess-taken path. Training comes from E-stage branch resolution.

---
 rtl/bpu_gshare.sv | 171 +++++++++++++++++
 tb/tb_bpu_gshare.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_gshare.sv
// bpu_gshare: direct-mapped BTB with 2-bit saturating counters, in bimodal
// (MODE=0) or gshare (MODE=1) indexing. The F-stage lookup is registered into
// D alignment. E-stage resolution trains the table and shifts the global
// history register.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   f_pc            F-stage fetch PC used for lookup
//   f_stall         hold all d_* outputs
//   d_flush         clear all d_* outputs (wins over f_stall)
//   d_pred_hit      registered: tag matched a valid entry
//   d_pred_taken    registered: hit and counter MSB set
//   d_pred_target   registered: stored target, 0 on miss
//   d_pred_idx      registered: table index used for the lookup
//   e_upd_valid     E-stage branch resolved this cycle (one pulse per branch)
//   e_upd_pc        PC of the resolved branch (tag source)
//   e_upd_idx       index carried from d_pred_idx (always used as-is)
//   e_upd_taken     resolved direction
//   e_upd_target    resolved target
module bpu_gshare #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned MODE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                f_pc,
    input  logic                       f_stall,
    input  logic                       d_flush,
    output logic                       d_pred_hit,
    output logic                       d_pred_taken,
    output logic [31:0]                d_pred_target,
    output logic [$clog2(ENTRIES)-1:0] d_pred_idx,
    input  logic                       e_upd_valid,
    input  logic [31:0]                e_upd_pc,
    input  logic [$clog2(ENTRIES)-1:0] e_upd_idx,
    input  logic                       e_upd_taken,
    input  logic [31:0]                e_upd_target
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    // Table storage (flop arrays).
    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [IDX_W-1:0]    ghr_q;
    logic [IDX_W-1:0]    ghr_d;

    // D-aligned lookup result.
    logic                d_hit_q;
    logic                d_taken_q;
    logic [31:0]         d_target_q;
    logic [IDX_W-1:0]    d_idx_q;

    // F-stage combinational lookup.
    logic [IDX_W-1:0]    idx_f;
    logic [TAG_W-1:0]    tag_f;
    logic                hit_f;
    logic                taken_f;
    logic [31:0]         target_f;

    // E-stage update decode.
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    logic                upd_alloc;
    logic                upd_wr_ctr;
    logic                upd_wr_tgt;
    logic [1:0]          upd_ctr_d;

    // Lookup: history only folds into the index in gshare mode.
    always_comb begin
        idx_f    = f_pc[TAG_LO-1:2] ^ ((MODE != 0) ? ghr_q : IDX_W'(0));
        tag_f    = f_pc[TAG_HI:TAG_LO];
        hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        taken_f  = hit_f && ctr_q[idx_f][1];
        target_f = hit_f ? target_q[idx_f] : 32'd0;
    end

    // Update decode: reads pre-update contents at e_upd_idx only.
    always_comb begin
        upd_tag    = e_upd_pc[TAG_HI:TAG_LO];
        upd_hit    = valid_q[e_upd_idx] && (tag_q[e_upd_idx] == upd_tag);
        upd_alloc  = 1'b0;
        upd_wr_ctr = 1'b0;
        upd_wr_tgt = 1'b0;
        upd_ctr_d  = ctr_q[e_upd_idx];
        ghr_d      = ghr_q;
        if (e_upd_valid) begin
            ghr_d = {ghr_q[IDX_W-2:0], e_upd_taken};
            if (e_upd_taken) begin
                upd_wr_ctr = 1'b1;
                upd_wr_tgt = 1'b1;
                if (upd_hit) begin
                    upd_ctr_d = (ctr_q[e_upd_idx] == 2'b11) ? 2'b11
                                                            : ctr_q[e_upd_idx] + 2'd1;
                end else begin
                    upd_alloc = 1'b1;
                    upd_ctr_d = 2'b10;
                end
            end else if (upd_hit) begin
                upd_wr_ctr = 1'b1;
                upd_ctr_d  = (ctr_q[e_upd_idx] == 2'b00) ? 2'b00
                                                         : ctr_q[e_upd_idx] - 2'd1;
            end
        end
    end

    // Valid bits, counters and history: the only table state that resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            if (upd_alloc) begin
                valid_q[e_upd_idx] <= 1'b1;
            end
            if (upd_wr_ctr) begin
                ctr_q[e_upd_idx] <= upd_ctr_d;
            end
        end
    end

    // Tag/target payload: no reset needed, qualified by valid.
    always_ff @(posedge clk) begin
        if (!rst && upd_alloc) begin
            tag_q[e_upd_idx] <= upd_tag;
        end
        if (!rst && upd_wr_tgt) begin
            target_q[e_upd_idx] <= e_upd_target;
        end
    end

    // D register: rst > d_flush > f_stall > load.
    always_ff @(posedge clk) begin
        if (rst || d_flush) begin
            d_hit_q    <= 1'b0;
            d_taken_q  <= 1'b0;
            d_target_q <= 32'd0;
            d_idx_q    <= '0;
        end else if (!f_stall) begin
            d_hit_q    <= hit_f;
            d_taken_q  <= taken_f;
            d_target_q <= target_f;
            d_idx_q    <= idx_f;
        end
    end

    assign d_pred_hit    = d_hit_q;
    assign d_pred_taken  = d_taken_q;
    assign d_pred_target = d_target_q;
    assign d_pred_idx    = d_idx_q;

    // PC bits outside the index/tag fields carry no information here.
    logic unused_hi;
    logic unused_pc;
    if (TAG_HI < 31) begin : g_hi_bits
        assign unused_hi = ^{f_pc[31:TAG_HI+1], e_upd_pc[31:TAG_HI+1]};
    end else begin : g_no_hi_bits
        assign unused_hi = 1'b0;
    end
    assign unused_pc = ^{f_pc[1:0], e_upd_pc[TAG_LO-1:0], unused_hi};

endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench for bpu_gshare: a bimodal 64-entry instance and a
// gshare 16-entry instance share stimulus; a reference model predicts each
// D-aligned result into a queue that is drained after the clock edge.
module tb_bpu_gshare;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, f_stall, d_flush, upd_v, upd_taken, sel;
    logic [31:0] f_pc, upd_pc, upd_tgt;
    logic [5:0]  upd_idx;
    logic        upd_v_a, upd_v_b;

    logic        a_hit, a_taken, b_hit, b_taken;
    logic [31:0] a_tgt, b_tgt;
    logic [5:0]  a_idx;
    logic [3:0]  b_idx;

    assign upd_v_a = upd_v & ~sel;
    assign upd_v_b = upd_v & sel;

    bpu_gshare #(.ENTRIES(64), .TAG_W(8), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_stall(f_stall), .d_flush(d_flush),
        .d_pred_hit(a_hit), .d_pred_taken(a_taken), .d_pred_target(a_tgt),
        .d_pred_idx(a_idx), .e_upd_valid(upd_v_a), .e_upd_pc(upd_pc),
        .e_upd_idx(upd_idx), .e_upd_taken(upd_taken), .e_upd_target(upd_tgt));

    bpu_gshare #(.ENTRIES(16), .TAG_W(8), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_stall(f_stall), .d_flush(d_flush),
        .d_pred_hit(b_hit), .d_pred_taken(b_taken), .d_pred_target(b_tgt),
        .d_pred_idx(b_idx), .e_upd_valid(upd_v_b), .e_upd_pc(upd_pc),
        .e_upd_idx(upd_idx[3:0]), .e_upd_taken(upd_taken), .e_upd_target(upd_tgt));

    logic        got_hit, got_taken;
    logic [31:0] got_tgt;
    logic [5:0]  got_idx;
    assign got_hit   = sel ? b_hit   : a_hit;
    assign got_taken = sel ? b_taken : a_taken;
    assign got_tgt   = sel ? b_tgt   : a_tgt;
    assign got_idx   = sel ? {2'b00, b_idx} : a_idx;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [5:0]  idx;
    } exp_t;

    exp_t sb[$];
    exp_t md;

    // Reference model of the instance under test.
    int unsigned m_w, m_mode;
    logic        m_valid [64];
    logic [7:0]  m_tag   [64];
    logic [31:0] m_tgt   [64];
    logic [1:0]  m_ctr   [64];
    logic [5:0]  m_ghr;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] mask_idx(input logic [31:0] v);
        return 6'(v & ((32'd1 << m_w) - 32'd1));
    endfunction

    function automatic logic [5:0] idx_of(input logic [31:0] pc);
        return mask_idx((pc >> 2) ^ ((m_mode != 0) ? {26'd0, m_ghr} : 32'd0));
    endfunction

    function automatic logic [7:0] tag_of(input logic [31:0] pc);
        return 8'(pc >> (m_w + 2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 2'b01;
            m_tag[i]   = 8'd0;
            m_tgt[i]   = 32'd0;
        end
        m_ghr = 6'd0;
    endtask

    // One clock: predict D result from pre-edge model state, apply update,
    // then compare after the edge.
    task automatic tick();
        exp_t        nx, e;
        logic [5:0]  i, ui;
        logic        h, uh;
        nx = md;
        if (rst || d_flush) begin
            nx = '0;
        end else if (!f_stall) begin
            i        = idx_of(f_pc);
            h        = m_valid[i] && (m_tag[i] == tag_of(f_pc));
            nx.hit   = h;
            nx.taken = h && m_ctr[i][1];
            nx.tgt   = h ? m_tgt[i] : 32'd0;
            nx.idx   = i;
        end
        md = nx;
        sb.push_back(nx);
        if (rst) begin
            model_reset();
        end else if (upd_v) begin
            ui = mask_idx({26'd0, upd_idx});
            uh = m_valid[ui] && (m_tag[ui] == tag_of(upd_pc));
            if (upd_taken) begin
                if (uh) begin
                    if (m_ctr[ui] != 2'd3) m_ctr[ui] = m_ctr[ui] + 2'd1;
                end else begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = tag_of(upd_pc);
                    m_ctr[ui]   = 2'b10;
                end
                m_tgt[ui] = upd_tgt;
            end else if (uh && m_ctr[ui] != 2'd0) begin
                m_ctr[ui] = m_ctr[ui] - 2'd1;
            end
            m_ghr = mask_idx({25'd0, m_ghr, upd_taken});
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("hit",    {31'd0, got_hit},   {31'd0, e.hit});
        chk("taken",  {31'd0, got_taken}, {31'd0, e.taken});
        chk("target", got_tgt,            e.tgt);
        chk("idx",    {26'd0, got_idx},   {26'd0, e.idx});
    endtask

    task automatic upd(input logic [31:0] pc, input logic [5:0] idx,
                       input logic tk, input logic [31:0] tgt);
        upd_v = 1'b1; upd_pc = pc; upd_idx = idx; upd_taken = tk; upd_tgt = tgt;
    endtask

    task automatic random_phase(input int n);
        for (int k = 0; k < n; k++) begin
            f_pc    = 32'h0040_0000 | (32'($urandom_range(0, 3)) << (m_w + 2))
                                    | (32'($urandom_range(0, 7)) << 2);
            upd_pc  = 32'h0040_0000 | (32'($urandom_range(0, 3)) << (m_w + 2))
                                    | (32'($urandom_range(0, 7)) << 2);
            upd_v   = 1'($urandom_range(0, 1));
            upd_idx = (m_mode != 0) ? mask_idx($urandom) : idx_of(upd_pc);
            upd_taken = 1'($urandom_range(0, 1));
            upd_tgt = $urandom & 32'hFFFF_FFFC;
            f_stall = ($urandom_range(0, 7) == 0);
            d_flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        upd_v = 1'b0; f_stall = 1'b0; d_flush = 1'b0;
    endtask

    initial begin
        sel = 1'b0; m_w = 6; m_mode = 0;
        rst = 1'b1; f_stall = 1'b0; d_flush = 1'b0; upd_v = 1'b0;
        upd_pc = 32'd0; upd_idx = 6'd0; upd_taken = 1'b0; upd_tgt = 32'd0;
        f_pc = 32'd0; md = '0;
        model_reset();
        @(posedge clk); #1;
        tick();
        chk("rst_hit", {31'd0, got_hit}, 32'd0);
        rst = 1'b0;

        // Cold lookup: miss at index 4.
        f_pc = 32'hBFC0_0010;
        tick();
        chk("cold_idx", {26'd0, got_idx}, 32'h4);
        chk("cold_tgt", got_tgt, 32'd0);

        // Allocation in the same cycle as a lookup: old value first.
        upd(32'hBFC0_0010, 6'h04, 1'b1, 32'hBFC0_0100);
        tick();
        chk("rbw_hit", {31'd0, got_hit}, 32'd0);
        upd_v = 1'b0;
        tick();
        chk("alloc_tgt",   got_tgt, 32'hBFC0_0100);
        chk("alloc_taken", {31'd0, got_taken}, 32'd1);

        // Counter walk: 3 not-taken, then 6 taken.
        for (int k = 0; k < 9; k++) begin
            upd(32'hBFC0_0010, 6'h04, (k >= 3), 32'hBFC0_0100);
            tick();
        end
        upd_v = 1'b0;
        tick();
        tick();
        chk("sat_taken", {31'd0, got_taken}, 32'd1);

        // Tag alias on index 4 then overwrite.
        f_pc = 32'hBFC0_1010;
        tick();
        chk("alias_hit", {31'd0, got_hit}, 32'd0);
        upd(32'hBFC0_1010, 6'h04, 1'b1, 32'hBFC0_2000);
        tick();
        upd_v = 1'b0;
        f_pc = 32'hBFC0_0010;
        tick();
        chk("old_tag_miss", {31'd0, got_hit}, 32'd0);
        f_pc = 32'hBFC0_1010;
        tick();
        chk("new_tag_tgt", got_tgt, 32'hBFC0_2000);

        // Stall holds, flush beats stall.
        f_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            f_pc = 32'h0000_1000 + 32'(k * 4);
            tick();
        end
        chk("stall_tgt", got_tgt, 32'hBFC0_2000);
        d_flush = 1'b1;
        tick();
        chk("flush_idx", {26'd0, got_idx}, 32'd0);
        f_stall = 1'b0; d_flush = 1'b0;
        random_phase(60);

        // Gshare instance; an update coinciding with reset is dropped.
        sel = 1'b1; m_w = 4; m_mode = 1;
        rst = 1'b1;
        upd(32'h0000_0010, 6'h04, 1'b1, 32'h0000_0BAD);
        tick();
        rst = 1'b0;
        upd(32'h0000_0040, 6'h00, 1'b1, 32'h0000_0400);
        tick();
        tick();
        upd_v = 1'b0;
        f_pc = 32'h0000_0010;
        tick();
        chk("gsh_idx", {26'd0, got_idx}, 32'h7);
        upd(32'h0000_0010, 6'h07, 1'b1, 32'h0000_1234);
        tick();
        upd_v = 1'b0;
        f_pc = 32'h0000_0000;
        tick();
        chk("e7_hit", {31'd0, got_hit}, 32'd1);
        chk("e7_tgt", got_tgt, 32'h0000_1234);
        f_pc = 32'h0000_000C;
        tick();
        chk("e4_idx",  {26'd0, got_idx}, 32'h4);
        chk("e4_miss", {31'd0, got_hit}, 32'd0);
        random_phase(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
